// File: rtl/measure_pkg.sv
// Shared constants, FSM encoding and field offsets for the XGMII
// measurement-frame generator and receive probe.
package measure_pkg;

    // XGMII control characters
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    // Protocol identifiers
    localparam logic [15:0] ETH_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_UDP   = 8'h11;

    // Project-wide measurement magic word
    localparam logic [31:0] MEASURE_MAGIC = 32'hCAFE_BABE;

    // Receive FSM states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_e;

    // Data-word index (start word is 0) carrying each header field
    localparam logic [15:0] WI_ETYPE  = 16'd2;
    localparam logic [15:0] WI_PROTO  = 16'd3;
    localparam logic [15:0] WI_DIP_HI = 16'd4;
    localparam logic [15:0] WI_DIP_LO = 16'd5;
    localparam logic [15:0] WI_MAGIC  = 16'd6;
    localparam logic [15:0] WI_TS_LO  = 16'd7;

    // First byte lane of each field inside its word (multi-byte fields are big-endian)
    localparam logic [2:0] ETYPE_LANE  = 3'd4;
    localparam logic [2:0] PROTO_LANE  = 3'd7;
    localparam logic [2:0] DIP_HI_LANE = 3'd6;
    localparam logic [2:0] DIP_LO_LANE = 3'd0;
    localparam logic [2:0] MAGIC_LANE  = 3'd2;
    localparam logic [2:0] TS_HI_LANE  = 3'd6;
    localparam logic [2:0] TS_LO_LANE  = 3'd0;

    // Clamp a 32-bit modular cycle difference into the 24-bit latency field
    function automatic logic [23:0] sat_latency(input logic [31:0] diff);
        return (diff[31:24] != 8'd0) ? 24'hFF_FFFF : diff[23:0];
    endfunction

endpackage

// File: rtl/measure_window_cnt.sv
// Per-second frame and byte counters with oneshot load/restart and saturation.
module measure_window_cnt
    import measure_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sec_i,
    input  logic        commit_i,
    input  logic [15:0] bytes_i,
    output logic [31:0] pps_o,
    output logic [31:0] bytes_o
);

    logic [31:0] frames_q, frames_d;
    logic [31:0] octets_q, octets_d;
    logic [31:0] pps_q, pps_d;
    logic [31:0] tput_q, tput_d;
    logic [32:0] octets_sum;

    assign octets_sum = {1'b0, octets_q} + {17'd0, bytes_i};

    // Window accumulation; a commit on the oneshot cycle lands in the new window
    always_comb begin
        frames_d = frames_q;
        octets_d = octets_q;
        pps_d    = pps_q;
        tput_d   = tput_q;
        if (sec_i) begin
            pps_d    = frames_q;
            tput_d   = octets_q;
            frames_d = commit_i ? 32'd1 : '0;
            octets_d = commit_i ? {16'd0, bytes_i} : '0;
        end else if (commit_i) begin
            frames_d = (frames_q == '1) ? '1 : frames_q + 32'd1;
            octets_d = octets_sum[32] ? '1 : octets_sum[31:0];
        end
    end

    // Counter and report registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frames_q <= '0;
            octets_q <= '0;
            pps_q    <= '0;
            tput_q   <= '0;
        end else begin
            frames_q <= frames_d;
            octets_q <= octets_d;
            pps_q    <= pps_d;
            tput_q   <= tput_d;
        end
    end

    assign pps_o   = pps_q;
    assign bytes_o = tput_q;

endmodule

// File: rtl/measure_rx_probe.sv
// XGMII RX probe: recognises IPv4/UDP measurement frames, measures one-way
// latency against the shared global counter and keeps per-second statistics.
module measure_rx_probe
    import measure_pkg::*;
#(
    parameter logic [31:0] MAGIC_CODE = MEASURE_MAGIC,
    parameter logic [15:0] MAX_WORDS  = 16'd190
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sec_oneshot,
    input  logic [31:0] global_counter,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic [31:0] rx_pps,
    output logic [31:0] rx_throughput,
    output logic [23:0] rx_latency,
    output logic [31:0] rx_ipv4_ip,
    output logic [31:0] rx_err_count
);

    rx_state_e   state_q, state_d;
    logic [15:0] wi_q, wi_d, cur_wi;
    logic [15:0] len_q, len_d;
    logic [31:0] dip_q, dip_d;
    logic [15:0] ts_hi_q, ts_hi_d;
    logic [23:0] lat_q, lat_d;
    logic [23:0] latency_q;
    logic [31:0] ip_q;
    logic [31:0] err_q;

    logic [7:0]  lane_b [8];
    logic        any_ctl, is_start, is_term;
    logic [2:0]  ctl_lane;
    logic [7:0]  ctl_byte;
    logic        commit, abort;
    logic [15:0] commit_len;
    logic [31:0] ts_full, lat_raw;

    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign lane_b[g] = xgmii_rxd[g*8 +: 8];
    end

    // Find the lowest lane carrying a control character
    always_comb begin
        ctl_lane = '0;
        ctl_byte = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (xgmii_rxc[3'(7 - i)]) begin
                ctl_lane = 3'(7 - i);
                ctl_byte = lane_b[3'(7 - i)];
            end
        end
    end

    assign any_ctl    = |xgmii_rxc;
    assign is_start   = xgmii_rxc[0] && (lane_b[0] == XGMII_START);
    assign is_term    = any_ctl && (ctl_byte == XGMII_TERM);
    assign cur_wi     = wi_q + 16'd1;
    assign commit_len = len_q + {13'd0, ctl_lane};
    assign ts_full    = {ts_hi_q, lane_b[TS_LO_LANE], lane_b[TS_LO_LANE + 3'd1]};
    assign lat_raw    = global_counter - ts_full;

    // Frame parser: next state, field capture, commit and abort strobes
    always_comb begin
        state_d = state_q;
        wi_d    = wi_q;
        len_d   = len_q;
        dip_d   = dip_q;
        ts_hi_d = ts_hi_q;
        lat_d   = lat_q;
        commit  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_start) begin
                    state_d = ST_HDR;
                    wi_d    = '0;
                    len_d   = '0;
                end
            end
            ST_HDR, ST_PAYLOAD: begin
                if (is_start) begin
                    abort   = 1'b1;
                    state_d = ST_HDR;
                    wi_d    = '0;
                    len_d   = '0;
                end else if (any_ctl) begin
                    state_d = ST_IDLE;
                    if (!is_term) begin
                        abort = 1'b1;
                    end else begin
                        // A terminate still inside the header is a runt: dropped silently
                        commit = (state_q == ST_PAYLOAD);
                    end
                end else if (cur_wi > MAX_WORDS) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wi_d  = cur_wi;
                    len_d = len_q + 16'd8;
                    if (state_q == ST_HDR) begin
                        case (cur_wi)
                            WI_ETYPE: begin
                                if ({lane_b[ETYPE_LANE], lane_b[ETYPE_LANE + 3'd1]} != ETH_IPV4)
                                    state_d = ST_DROP;
                            end
                            WI_PROTO: begin
                                if (lane_b[PROTO_LANE] != IP_UDP)
                                    state_d = ST_DROP;
                            end
                            WI_DIP_HI: begin
                                dip_d[31:16] = {lane_b[DIP_HI_LANE], lane_b[DIP_HI_LANE + 3'd1]};
                            end
                            WI_DIP_LO: begin
                                dip_d[15:0] = {lane_b[DIP_LO_LANE], lane_b[DIP_LO_LANE + 3'd1]};
                            end
                            WI_MAGIC: begin
                                if ({lane_b[MAGIC_LANE], lane_b[MAGIC_LANE + 3'd1],
                                     lane_b[MAGIC_LANE + 3'd2], lane_b[MAGIC_LANE + 3'd3]} != MAGIC_CODE)
                                    state_d = ST_DROP;
                                ts_hi_d = {lane_b[TS_HI_LANE], lane_b[TS_HI_LANE + 3'd1]};
                            end
                            WI_TS_LO: begin
                                lat_d   = sat_latency(lat_raw);
                                state_d = ST_PAYLOAD;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_DROP: begin
                if (is_start) begin
                    state_d = ST_HDR;
                    wi_d    = '0;
                    len_d   = '0;
                end else if (any_ctl) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Parser state, pending fields and committed result registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            wi_q      <= '0;
            len_q     <= '0;
            dip_q     <= '0;
            ts_hi_q   <= '0;
            lat_q     <= '0;
            latency_q <= '0;
            ip_q      <= '0;
            err_q     <= '0;
        end else begin
            state_q <= state_d;
            wi_q    <= wi_d;
            len_q   <= len_d;
            dip_q   <= dip_d;
            ts_hi_q <= ts_hi_d;
            lat_q   <= lat_d;
            if (commit) begin
                latency_q <= lat_q;
                ip_q      <= dip_q;
            end
            if (abort) begin
                err_q <= err_q + 32'd1;
            end
        end
    end

    measure_window_cnt u_window (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .sec_i    (sec_oneshot),
        .commit_i (commit),
        .bytes_i  (commit_len),
        .pps_o    (rx_pps),
        .bytes_o  (rx_throughput)
    );

    assign rx_latency   = latency_q;
    assign rx_ipv4_ip   = ip_q;
    assign rx_err_count = err_q;

endmodule

// File: tb/tb_measure_rx_probe.sv
// Directed self-checking bench for measure_rx_probe.
module tb_measure_rx_probe;

    localparam logic [63:0] IDLE_W  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] START_W = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] L4ST_W  = 64'h5555_55FB_0707_0707;
    localparam logic [31:0] MAGIC   = 32'hCAFE_BABE;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        sec_oneshot = 1'b0;
    logic [31:0] global_counter = '0;
    logic [63:0] xgmii_rxd = IDLE_W;
    logic [7:0]  xgmii_rxc = 8'hFF;
    logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip, rx_err_count;
    logic [23:0] rx_latency;

    int checks = 0;
    int errors = 0;
    logic [7:0] fb [0:2047];

    measure_rx_probe #(
        .MAGIC_CODE (MAGIC),
        .MAX_WORDS  (16'd190)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .sec_oneshot    (sec_oneshot),
        .global_counter (global_counter),
        .xgmii_rxd      (xgmii_rxd),
        .xgmii_rxc      (xgmii_rxc),
        .rx_pps         (rx_pps),
        .rx_throughput  (rx_throughput),
        .rx_latency     (rx_latency),
        .rx_ipv4_ip     (rx_ipv4_ip),
        .rx_err_count   (rx_err_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge, the DUT samples on the rising edge
    task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic s);
        @(negedge sys_clk);
        xgmii_rxd   = d;
        xgmii_rxc   = c;
        sec_oneshot = s;
    endtask

    task automatic idle_word();
        drive(IDLE_W, 8'hFF, 1'b0);
    endtask

    task automatic sec_pulse();
        drive(IDLE_W, 8'hFF, 1'b1);
        drive(IDLE_W, 8'hFF, 1'b0);
    endtask

    task automatic build_frame(input logic [31:0] ip, input logic [31:0] ts,
                               input logic [31:0] magic, input logic [15:0] etype,
                               input int unsigned len);
        for (int unsigned i = 0; i < len; i++) fb[i] = 8'(i);
        fb[12] = etype[15:8]; fb[13] = etype[7:0];
        fb[14] = 8'h45;       fb[23] = 8'h11;
        fb[30] = ip[31:24];   fb[31] = ip[23:16]; fb[32] = ip[15:8];   fb[33] = ip[7:0];
        fb[42] = magic[31:24]; fb[43] = magic[23:16]; fb[44] = magic[15:8]; fb[45] = magic[7:0];
        fb[46] = ts[31:24];   fb[47] = ts[23:16]; fb[48] = ts[15:8];   fb[49] = ts[7:0];
    endtask

    function automatic logic [63:0] data_word(input int unsigned w);
        logic [63:0] r;
        for (int unsigned b = 0; b < 8; b++) r[8*b +: 8] = fb[w*8 + b];
        return r;
    endfunction

    task automatic send_frame(input int unsigned len, input logic term_sec, input logic lane4_start);
        logic [63:0] t;
        int unsigned k;
        if (lane4_start) drive(L4ST_W, 8'h1F, 1'b0);
        else             drive(START_W, 8'h01, 1'b0);
        for (int unsigned w = 0; w < len / 8; w++) drive(data_word(w), 8'h00, 1'b0);
        k = len % 8;
        for (int unsigned b = 0; b < 8; b++) begin
            if (b < k)       t[8*b +: 8] = fb[(len / 8) * 8 + b];
            else if (b == k) t[8*b +: 8] = 8'hFD;
            else             t[8*b +: 8] = 8'h07;
        end
        drive(t, 8'(8'hFF << k), term_sec);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pps"},  rx_pps, 32'd0);
        check_eq({tag, "_tput"}, rx_throughput, 32'd0);
        check_eq({tag, "_lat"},  {8'd0, rx_latency}, 32'd0);
        check_eq({tag, "_ip"},   rx_ipv4_ip, 32'd0);
        check_eq({tag, "_err"},  rx_err_count, 32'd0);
    endtask

    initial begin
        logic [63:0] w;

        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        sys_rst = 1'b0;

        // Single 64-byte frame
        global_counter = 32'd1150;
        build_frame(32'h0A00_0001, 32'd1000, MAGIC, 16'h0800, 64);
        send_frame(64, 1'b0, 1'b0);
        idle_word();
        check_eq("single_lat", {8'd0, rx_latency}, 32'd150);
        check_eq("single_ip", rx_ipv4_ip, 32'h0A00_0001);
        check_eq("single_pps_before_sec", rx_pps, 32'd0);
        sec_pulse();
        check_eq("single_pps", rx_pps, 32'd1);
        check_eq("single_tput", rx_throughput, 32'd64);

        // Ten back-to-back frames with one idle word between
        for (int unsigned f = 0; f < 10; f++) begin
            global_counter = 32'd2000 + f;
            build_frame(32'h0A00_0000 + f, 32'd1990, MAGIC, 16'h0800, 64);
            send_frame(64, 1'b0, 1'b0);
            idle_word();
        end
        check_eq("b2b_ip", rx_ipv4_ip, 32'h0A00_0009);
        check_eq("b2b_lat", {8'd0, rx_latency}, 32'd19);
        sec_pulse();
        check_eq("b2b_pps", rx_pps, 32'd10);
        check_eq("b2b_tput", rx_throughput, 32'd640);
        check_eq("b2b_err", rx_err_count, 32'd0);

        // Wrong magic, then IPv6 ethertype: both dropped silently
        build_frame(32'h0B00_0001, 32'd0, 32'hDEAD_BEEF, 16'h0800, 64);
        send_frame(64, 1'b0, 1'b0);
        idle_word();
        build_frame(32'h0B00_0002, 32'd0, MAGIC, 16'h86DD, 64);
        send_frame(64, 1'b0, 1'b0);
        idle_word();
        check_eq("drop_ip", rx_ipv4_ip, 32'h0A00_0009);
        sec_pulse();
        check_eq("drop_pps", rx_pps, 32'd0);
        check_eq("drop_tput", rx_throughput, 32'd0);
        check_eq("drop_err", rx_err_count, 32'd0);

        // Counter wrap and latency saturation
        global_counter = 32'h0000_0010;
        build_frame(32'h0A00_00AA, 32'hFFFF_FFF0, MAGIC, 16'h0800, 64);
        send_frame(64, 1'b0, 1'b0);
        idle_word();
        check_eq("wrap_lat", {8'd0, rx_latency}, 32'd32);
        global_counter = 32'h0300_0000;
        build_frame(32'h0A00_00BB, 32'h0100_0000, MAGIC, 16'h0800, 64);
        send_frame(64, 1'b0, 1'b0);
        idle_word();
        check_eq("sat_lat", {8'd0, rx_latency}, 32'h00FF_FFFF);
        check_eq("sat_ip", rx_ipv4_ip, 32'h0A00_00BB);
        sec_pulse();
        check_eq("wrap_pps", rx_pps, 32'd2);
        check_eq("wrap_tput", rx_throughput, 32'd128);

        // Truncated by an error char in lane 3 at word 5
        build_frame(32'h0C00_0001, 32'd0, MAGIC, 16'h0800, 64);
        drive(START_W, 8'h01, 1'b0);
        for (int unsigned i = 0; i < 4; i++) drive(data_word(i), 8'h00, 1'b0);
        w = data_word(4);
        w[31:24] = 8'hFE;
        drive(w, 8'h08, 1'b0);
        idle_word();
        check_eq("trunc_err", rx_err_count, 32'd1);
        check_eq("trunc_ip", rx_ipv4_ip, 32'h0A00_00BB);

        // Start in lane 4 is ignored
        build_frame(32'h0C00_0002, 32'd0, MAGIC, 16'h0800, 64);
        send_frame(64, 1'b0, 1'b1);
        idle_word();
        sec_pulse();
        check_eq("lane4_pps", rx_pps, 32'd0);
        check_eq("lane4_err", rx_err_count, 32'd1);

        // New start while in payload aborts, the second frame commits
        build_frame(32'h0C00_0003, 32'd100, MAGIC, 16'h0800, 64);
        drive(START_W, 8'h01, 1'b0);
        for (int unsigned i = 0; i < 9; i++) drive(data_word(i), 8'h00, 1'b0);
        global_counter = 32'd520;
        build_frame(32'hC0A8_0102, 32'd500, MAGIC, 16'h0800, 64);
        send_frame(64, 1'b0, 1'b0);
        idle_word();
        check_eq("restart_err", rx_err_count, 32'd2);
        check_eq("restart_lat", {8'd0, rx_latency}, 32'd20);
        check_eq("restart_ip", rx_ipv4_ip, 32'hC0A8_0102);
        sec_pulse();
        check_eq("restart_pps", rx_pps, 32'd1);
        check_eq("restart_tput", rx_throughput, 32'd64);

        // Terminate (lane 3, 67 bytes) coincident with the oneshot
        global_counter = 32'd3000;
        build_frame(32'h0D00_0001, 32'd2990, MAGIC, 16'h0800, 67);
        send_frame(67, 1'b1, 1'b0);
        idle_word();
        check_eq("coinc_pps", rx_pps, 32'd0);
        check_eq("coinc_tput", rx_throughput, 32'd0);
        check_eq("coinc_lat", {8'd0, rx_latency}, 32'd10);
        sec_pulse();
        check_eq("coinc_next_pps", rx_pps, 32'd1);
        check_eq("coinc_next_tput", rx_throughput, 32'd67);

        // Runaway frame (191 data words) aborts; 190 words still commits
        build_frame(32'h0E00_0001, 32'd0, MAGIC, 16'h0800, 1528);
        send_frame(1528, 1'b0, 1'b0);
        idle_word();
        check_eq("runaway_err", rx_err_count, 32'd3);
        check_eq("runaway_ip", rx_ipv4_ip, 32'h0D00_0001);
        global_counter = 32'd107;
        build_frame(32'h0F00_0001, 32'd7, MAGIC, 16'h0800, 1520);
        send_frame(1520, 1'b0, 1'b0);
        idle_word();
        check_eq("maxlen_lat", {8'd0, rx_latency}, 32'd100);
        check_eq("maxlen_ip", rx_ipv4_ip, 32'h0F00_0001);
        sec_pulse();
        check_eq("maxlen_pps", rx_pps, 32'd1);
        check_eq("maxlen_tput", rx_throughput, 32'd1520);

        // Reset in the middle of a frame
        build_frame(32'h1000_0009, 32'd0, MAGIC, 16'h0800, 64);
        drive(START_W, 8'h01, 1'b0);
        for (int unsigned i = 0; i < 3; i++) drive(data_word(i), 8'h00, 1'b0);
        #2 sys_rst = 1'b1;
        drive(data_word(3), 8'h00, 1'b0);
        drive(data_word(4), 8'h00, 1'b0);
        check_all_zero("midrst");
        sys_rst = 1'b0;
        for (int unsigned i = 5; i < 8; i++) drive(data_word(i), 8'h00, 1'b0);
        idle_word();
        check_eq("postrst_err0", rx_err_count, 32'd0);
        check_eq("postrst_ip0", rx_ipv4_ip, 32'd0);
        global_counter = 32'd45;
        build_frame(32'h1000_0001, 32'd40, MAGIC, 16'h0800, 64);
        send_frame(64, 1'b0, 1'b0);
        idle_word();
        check_eq("postrst_lat", {8'd0, rx_latency}, 32'd5);
        check_eq("postrst_ip", rx_ipv4_ip, 32'h1000_0001);
        check_eq("postrst_err", rx_err_count, 32'd0);
        sec_pulse();
        check_eq("postrst_pps", rx_pps, 32'd1);
        check_eq("postrst_tput", rx_throughput, 32'd64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
